// File: rtl/morse_output_fsm.sv
// Morse character playback: turns a latched dot/dash pattern into
// timed on/off keying with inter-element gaps and an inter-letter tail.
module morse_output_fsm #(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] morse_code,
    input  logic [2:0] morse_len,
    input  logic       abort,
    output logic       tone_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] elem_idx
);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        TAIL
    } state_t;

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(3 * UNIT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       code_q, code_n;
    logic [2:0]       len_q, len_n;
    logic [2:0]       idx_n;
    logic             tone_n;
    logic             done_n;
    logic             len_ok;
    logic             last_elem;
    logic             cnt_zero;

    // Counter preload for the mark of element idx (first element at bit len-1)
    function automatic logic [CNT_W-1:0] mark_ld(
        input logic [4:0] code,
        input logic [2:0] len,
        input logic [2:0] idx
    );
        logic [2:0] pos;
        logic [4:0] sh;
        pos = len - 3'd1 - idx;
        sh  = code >> pos;
        return sh[0] ? DASH_LD : DOT_LD;
    endfunction

    assign len_ok    = (morse_len != 3'd0) && (morse_len <= 3'd5);
    assign last_elem = (elem_idx == len_q - 3'd1);
    assign cnt_zero  = (cnt == '0);

    // State register plus latched character and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            code_q   <= '0;
            len_q    <= '0;
            elem_idx <= '0;
            tone_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            code_q   <= code_n;
            len_q    <= len_n;
            elem_idx <= idx_n;
            tone_out <= tone_n;
            done     <= done_n;
        end
    end

    // Next-state, duration counter and element sequencing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        len_n   = len_q;
        idx_n   = elem_idx;
        unique case (state)
            IDLE: begin
                if (start && len_ok) begin
                    code_n  = morse_code;
                    len_n   = morse_len;
                    idx_n   = 3'd0;
                    state_n = MARK;
                    cnt_n   = mark_ld(morse_code, morse_len, 3'd0);
                end
            end
            MARK: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else if (!last_elem) begin
                    state_n = GAP;
                    cnt_n   = DOT_LD;
                end else begin
                    state_n = TAIL;
                    cnt_n   = DASH_LD;
                end
            end
            GAP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    idx_n   = elem_idx + 3'd1;
                    state_n = MARK;
                    cnt_n   = mark_ld(code_q, len_q, elem_idx + 3'd1);
                end
            end
            TAIL: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (state != IDLE && abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = 3'd0;
        end
    end

    // Output decode: tone follows the next state, done marks a clean tail end
    always_comb begin
        busy   = (state != IDLE);
        tone_n = (state_n == MARK);
        done_n = (state == TAIL) && cnt_zero && !abort;
    end

endmodule

// File: tb/tb_morse_output_fsm.sv
// Bench for morse_output_fsm: timeline model of the keying waveform,
// directed character cases plus randomized start/abort/reset traffic.
module tb_morse_output_fsm;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] morse_code;
    logic [2:0] morse_len;
    logic       tone_out;
    logic       busy;
    logic       done;
    logic [2:0] elem_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    morse_output_fsm #(
        .UNIT_CYCLES(U),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .morse_code(morse_code),
        .morse_len(morse_len),
        .abort(abort),
        .tone_out(tone_out),
        .busy(busy),
        .done(done),
        .elem_idx(elem_idx)
    );

    typedef struct packed {
        logic       tone;
        logic       busy;
        logic       done;
        logic       chk;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   ok   = 1'b0;
    bit   zero = 1'b1;

    function automatic exp_t mk(bit t, bit b, bit d, bit c, int i);
        exp_t e;
        e.tone = t;
        e.busy = b;
        e.done = d;
        e.chk  = c;
        e.idx  = 3'(i);
        return e;
    endfunction

    // Expand one character into its cycle-by-cycle expected waveform
    function automatic void enqueue(logic [4:0] c, logic [2:0] l);
        int m;
        int p;
        int n;
        n = int'(l);
        for (int i = 0; i < n; i++) begin
            m = c[n-1-i] ? 3 * U : U;
            p = (i < n - 1) ? U : 3 * U;
            for (int k = 0; k < m; k++) q.push_back(mk(1, 1, 0, 1, i));
            for (int k = 0; k < p; k++) q.push_back(mk(0, 1, 0, 1, i));
        end
        q.push_back(mk(0, 0, 1, 0, 0));
    endfunction

    // Reference model advances one cycle per rising edge
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            zero = 1'b1;
            ok   = 1'b1;
            cur  = mk(0, 0, 0, 1, 0);
        end else if (ok) begin
            if (abort && cur.busy) begin
                q.delete();
                zero = 1'b1;
                cur  = mk(0, 0, 0, 1, 0);
            end else if (start && !cur.busy &&
                         morse_len >= 3'd1 && morse_len <= 3'd5) begin
                q.delete();
                enqueue(morse_code, morse_len);
                zero = 1'b0;
                cur  = q.pop_front();
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(0, 0, 0, zero, 0);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (ok) begin
            chk("tone_out", 32'(tone_out), 32'(cur.tone));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            if (cur.chk) chk("elem_idx", 32'(elem_idx), 32'(cur.idx));
        end
    end

    task automatic play(
        input  logic [4:0] c,
        input  logic [2:0] l,
        input  bit         intrude,
        output int         nb,
        output int         nt,
        output int         tf,
        output int         tl,
        output int         dn
    );
        start      = 1'b1;
        morse_code = c;
        morse_len  = l;
        nb = 0; nt = 0; tf = 0; tl = 0; dn = 0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (busy) nb++;
            if (tone_out) begin
                nt++;
                if (tf == 0) tf = n;
                tl = n;
            end
            if (done) begin
                dn = n;
                break;
            end
            if (intrude && n == 5) begin
                start      = 1'b1;
                morse_code = 5'b11111;
                morse_len  = 3'd5;
            end else if (intrude && n == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (dn == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL play_timeout: got no done expected done pulse");
        end
    endtask

    task automatic cancel_test(input bit use_rst, input string tag);
        int nd;
        start      = 1'b1;
        morse_code = 5'b00001;
        morse_len  = 3'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        chk({tag, "_tone"}, 32'(tone_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idx"}, 32'(elem_idx), 32'd0);
        nd = 0;
        repeat (20) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk({tag, "_no_done"}, 32'(nd), 32'd0);
    endtask

    int nb, nt, tf, tl, dn;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        morse_code = 5'd0;
        morse_len  = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_tone", 32'(tone_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(elem_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        play(5'b00000, 3'd1, 1'b0, nb, nt, tf, tl, dn);
        chk("E_busy", 32'(nb), 32'd16);
        chk("E_tone", 32'(nt), 32'd4);
        chk("E_tone_last", 32'(tl), 32'd4);
        chk("E_done", 32'(dn), 32'd17);
        repeat (3) @(negedge clk);

        play(5'b00001, 3'd2, 1'b0, nb, nt, tf, tl, dn);
        chk("A_busy", 32'(nb), 32'd32);
        chk("A_tone", 32'(nt), 32'd16);
        chk("A_tone_last", 32'(tl), 32'd20);
        chk("A_done", 32'(dn), 32'd33);
        repeat (3) @(negedge clk);

        play(5'b11111, 3'd5, 1'b0, nb, nt, tf, tl, dn);
        chk("0_busy", 32'(nb), 32'd88);
        chk("0_tone", 32'(nt), 32'd60);
        chk("0_tone_last", 32'(tl), 32'd76);
        chk("0_done", 32'(dn), 32'd89);
        repeat (3) @(negedge clk);

        start     = 1'b1;
        morse_len = 3'd0;
        @(negedge clk);
        chk("len0_busy", 32'(busy), 32'd0);
        morse_len = 3'd6;
        @(negedge clk);
        chk("len6_busy", 32'(busy), 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        play(5'b00000, 3'd1, 1'b1, nb, nt, tf, tl, dn);
        chk("Eblk_busy", 32'(nb), 32'd16);
        chk("Eblk_tone", 32'(nt), 32'd4);
        chk("Eblk_done", 32'(dn), 32'd17);
        repeat (3) @(negedge clk);

        play(5'b00000, 3'd1, 1'b0, nb, nt, tf, tl, dn);
        chk("b2b_E_done", 32'(dn), 32'd17);
        play(5'b00001, 3'd1, 1'b0, nb, nt, tf, tl, dn);
        chk("b2b_T_first", 32'(17 + tf), 32'd18);
        chk("b2b_T_last", 32'(17 + tl), 32'd29);
        chk("b2b_T_done", 32'(17 + dn), 32'd42);
        repeat (3) @(negedge clk);

        cancel_test(1'b0, "abort");
        cancel_test(1'b1, "reset");

        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            morse_code = 5'($urandom);
            morse_len  = 3'($urandom);
            abort      = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
